calc_multi: RTL and testbench

Parametrised second-generation decimal calculator core. Accepts a keypad command stream with a valid/ready handshake and builds two decimal operands. It computes add, subtract and multiply (divide optional) with iterative shift-add/restoring datapaths, then serialises the result digit-by-digit to the display controller over `data`/`pos`. Adds sign, overflow detection, operand length limits, result chaining and error recovery.

---
 rtl/calc_pkg.sv | 39 +++
 rtl/calc_iter_alu.sv | 91 +++++++++
 rtl/calc_multi.sv | 188 ++++++++++++++++++
 tb/tb_calc_multi.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared command codes, status/state encodings and display constants for the calculator core.
// Optional divide support is selected with the CALC_DIV_EN macro.
package calc_pkg;

  localparam logic [3:0] CMD_ADD = 4'd10;
  localparam logic [3:0] CMD_SUB = 4'd11;
  localparam logic [3:0] CMD_MUL = 4'd12;
  localparam logic [3:0] CMD_DIV = 4'd13;
  localparam logic [3:0] CMD_EQ  = 4'd14;
  localparam logic [3:0] CMD_BS  = 4'd15;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [3:0] ERR_DIGIT = 4'hE;

  typedef enum logic [1:0] {
    ERROR    = 2'b00,
    BUSY     = 2'b01,
    READY    = 2'b10,
    PRINTING = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    CALC,
    PRINT,
    ERR
  } state_t;

  // Divide is only a legal operator when the divider is compiled in.
  function automatic logic is_operator(input logic [3:0] c);
`ifdef CALC_DIV_EN
    return c inside {CMD_ADD, CMD_SUB, CMD_MUL, CMD_DIV};
`else
    return c inside {CMD_ADD, CMD_SUB, CMD_MUL};
`endif
  endfunction

endpackage

// File: rtl/calc_iter_alu.sv
// Iterative shift-add multiplier, plus a restoring divider when CALC_DIV_EN is defined.
// The first step is folded into the start cycle so a full operation takes WIDTH cycles.
module calc_iter_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
`ifdef CALC_DIV_EN
  input  logic               div,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               busy;

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0] rem, dvd, divisor;
  logic             is_div;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] dv);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] s;
    t = {r, d[WIDTH-1]};
    s = t[WIDTH-1:0] - dv;
    if (t >= {1'b0, dv}) return {s, d[WIDTH-2:0], 1'b1};
    return {t[WIDTH-1:0], d[WIDTH-2:0], 1'b0};
  endfunction

  assign result = is_div ? {{WIDTH{1'b0}}, dvd} : prod;
`else
  assign result = prod;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
`ifdef CALC_DIV_EN
      rem     <= '0;
      dvd     <= '0;
      divisor <= '0;
      is_div  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        busy   <= 1'b1;
        cnt    <= CW'(WIDTH - 1);
        prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
        mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
`ifdef CALC_DIV_EN
        {rem, dvd} <= div_step('0, a, b);
        divisor    <= b;
        is_div     <= div;
`endif
      end else if (busy) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
`ifdef CALC_DIV_EN
        {rem, dvd} <= div_step(rem, dvd, divisor);
`endif
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/calc_multi.sv
// Decimal calculator core: keypad entry FSM, add/sub/mul(/div with CALC_DIV_EN) and
// LSD-first digit serialiser for the display controller.
module calc_multi
  import calc_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int WIDTH  = 27,
  parameter int POS_W  = $clog2(DIGITS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [1:0]       status,
  output logic [3:0]       data,
  output logic [POS_W-1:0] pos,
  output logic             neg
);

  localparam int                 CNT_W = $clog2(DIGITS + 1);
  localparam logic [WIDTH-1:0]   TEN   = WIDTH'(10);
  localparam logic [WIDTH-1:0]   FULL  = WIDTH'(10 ** (DIGITS - 1));
  localparam logic [2*WIDTH-1:0] MAXV  = (2*WIDTH)'(10 ** DIGITS - 1);

  state_t             state, ret;
  status_t            st;
  logic [WIDTH-1:0]   acc, opa, opb, prt, nxt, dig, diff;
  logic [WIDTH:0]     sum;
  logic [3:0]         op;
  logic [CNT_W-1:0]   cnt;
  logic               chain, accept, upd, a_lt_b, div_zero;
  logic               alu_start, alu_done;
  logic [2*WIDTH-1:0] alu_res;

  assign cmd_ready = (state == ENTER_A) || (state == ENTER_B) || (state == ERR);
  assign accept    = cmd_valid && cmd_ready;
  assign status    = st;
  assign dig       = {{(WIDTH-4){1'b0}}, cmd};
  assign sum       = {1'b0, opa} + {1'b0, opb};
  assign a_lt_b    = opa < opb;
  assign diff      = a_lt_b ? opb - opa : opa - opb;
  assign alu_start = accept && (state == ENTER_B) && (cmd == CMD_EQ) &&
                     (op != CMD_ADD) && (op != CMD_SUB);
`ifdef CALC_DIV_EN
  assign div_zero  = (op == CMD_DIV) && (opb == '0);
`else
  assign div_zero  = 1'b0;
`endif

  calc_iter_alu #(.WIDTH(WIDTH)) u_alu (
    .clock  (clock),
    .reset  (reset),
    .start  (alu_start),
`ifdef CALC_DIV_EN
    .div    (op == CMD_DIV),
`endif
    .a      (opa),
    .b      (acc),
    .done   (alu_done),
    .result (alu_res)
  );

  // Entry edit: a digit after a chained result starts a fresh number.
  always_comb begin
    upd = 1'b0;
    nxt = acc;
    if (cmd <= 4'd9) begin
      if (state == ENTER_A && chain) begin
        upd = 1'b1;
        nxt = dig;
      end else if (acc < FULL) begin
        upd = 1'b1;
        nxt = acc * TEN + dig;
      end
    end else if (cmd == CMD_BS) begin
      upd = 1'b1;
      nxt = acc / TEN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ENTER_A;
      ret   <= ENTER_A;
      st    <= READY;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      op    <= '0;
      prt   <= '0;
      cnt   <= '0;
      chain <= 1'b0;
      neg   <= 1'b0;
      data  <= '0;
      pos   <= '0;
    end else begin
      case (state)
        ENTER_A, ENTER_B: if (accept) begin
          if (cmd <= 4'd9 || cmd == CMD_BS) begin
            if (cmd <= 4'd9) begin
              neg   <= 1'b0;
              chain <= 1'b0;
            end
            if (upd) begin
              acc   <= nxt;
              prt   <= nxt;
              cnt   <= '0;
              ret   <= state;
              st    <= BUSY;
              state <= PRINT;
            end
          end else if (cmd == CMD_EQ) begin
            if (state == ENTER_B) begin
              opb   <= acc;
              st    <= BUSY;
              state <= CALC;
            end
          end else if (state == ENTER_B || !is_operator(cmd)) begin
            st    <= ERROR;
            data  <= ERR_DIGIT;
            pos   <= '0;
            state <= ERR;
          end else begin
            opa   <= acc;
            op    <= cmd;
            acc   <= '0;
            chain <= 1'b0;
            state <= ENTER_B;
          end
        end
        CALC: begin
          if (op == CMD_ADD || op == CMD_SUB || alu_done) begin
            if ((op == CMD_ADD && {{(WIDTH-1){1'b0}}, sum} > MAXV) ||
                (op != CMD_ADD && op != CMD_SUB && (div_zero || alu_res > MAXV))) begin
              st    <= ERROR;
              data  <= ERR_DIGIT;
              pos   <= '0;
              state <= ERR;
            end else begin
              if (op == CMD_ADD) begin
                acc <= sum[WIDTH-1:0];
                prt <= sum[WIDTH-1:0];
              end else if (op == CMD_SUB) begin
                acc <= diff;
                prt <= diff;
              end else begin
                acc <= alu_res[WIDTH-1:0];
                prt <= alu_res[WIDTH-1:0];
              end
              neg   <= (op == CMD_SUB) && a_lt_b;
              chain <= 1'b1;
              cnt   <= '0;
              ret   <= ENTER_A;
              state <= PRINT;
            end
          end
        end
        PRINT: begin
          if (cnt == CNT_W'(DIGITS)) begin
            st    <= READY;
            state <= ret;
          end else begin
            pos  <= POS_W'(cnt);
            data <= (prt == '0 && cnt != '0) ? BLANK : 4'(prt % TEN);
            prt  <= prt / TEN;
            cnt  <= cnt + 1'b1;
            st   <= PRINTING;
          end
        end
        ERR: if (accept && cmd == CMD_BS) begin
          acc   <= '0;
          opa   <= '0;
          opb   <= '0;
          op    <= '0;
          chain <= 1'b0;
          neg   <= 1'b0;
          data  <= '0;
          pos   <= '0;
          st    <= READY;
          state <= ENTER_A;
        end
        default: state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_multi.sv
// Bench for calc_multi: directed test-plan steps followed by random keypad traffic,
// all checked against an arithmetic model of the calculator.
module tb_calc_multi;

  localparam int D = 8;
  localparam int W = 27;
  localparam int PW = $clog2(D);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cmd = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;
  logic          neg;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: m_st 0 = entering A, 1 = entering B, 2 = error
  longint m_acc, m_a;
  int     m_op, m_st;
  bit     m_neg, m_chain;

  calc_multi #(.DIGITS(D), .WIDTH(W), .POS_W(PW)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .status    (status),
    .data      (data),
    .pos       (pos),
    .neg       (neg)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic longint pow10(input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [3:0] exp_digit(input longint v, input int k);
    if (k != 0 && v < pow10(k)) return 4'hF;
    return 4'((v / pow10(k)) % 10);
  endfunction

  function automatic bit valid_op(input int c);
`ifdef CALC_DIV_EN
    return c >= 10 && c <= 13;
`else
    return c >= 10 && c <= 12;
`endif
  endfunction

  task automatic model_clear();
    m_acc = 0; m_a = 0; m_op = 0; m_st = 0; m_neg = 0; m_chain = 0;
  endtask

  task automatic send(input logic [3:0] c);
    int t = 0;
    @(negedge clock);
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (cmd_ready !== 1'b1) check("ready_wait", {63'd0, cmd_ready}, 64'd1);
    cmd = c;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Apply one command to the model, send it, and check what the display does.
  task automatic do_cmd(input int c, input bit hold = 1'b0);
    int     kind = 0;   // 0 no print, 1 print, 2 error, 3 clear from error
    int     exp_lat = 1;
    int     lat;
    longint val = 0;
    longint r;
    bit     bad;
    if (m_st == 2) begin
      if (c == 15) begin
        model_clear();
        kind = 3;
      end
    end else if (c <= 9) begin
      m_neg = 0;
      if (m_st == 0 && m_chain) begin
        m_acc = c; m_chain = 0; kind = 1;
      end else if (m_acc < pow10(D - 1)) begin
        m_acc = m_acc * 10 + c; kind = 1;
      end
      val = m_acc;
    end else if (c == 15) begin
      m_acc = m_acc / 10; val = m_acc; kind = 1;
    end else if (c == 14) begin
      if (m_st == 1) begin
        bad = 0;
        exp_lat = 2;
        case (m_op)
          10: r = m_a + m_acc;
          11: r = (m_a >= m_acc) ? m_a - m_acc : m_acc - m_a;
          12: begin r = m_a * m_acc; exp_lat = W + 1; end
          default: begin
            exp_lat = W + 1;
            if (m_acc == 0) begin bad = 1; r = 0; end
            else r = m_a / m_acc;
          end
        endcase
        if (bad || r > pow10(D) - 1) begin
          kind = 2; m_st = 2;
        end else begin
          m_neg = (m_op == 11) && (m_a < m_acc);
          m_acc = r; val = r; m_st = 0; m_chain = 1; kind = 1;
        end
      end
    end else begin
      if (m_st == 1 || !valid_op(c)) begin
        kind = 2; m_st = 2;
      end else begin
        m_a = m_acc; m_op = c; m_acc = 0; m_chain = 0; m_st = 1;
      end
    end

    send(4'(c));
    if (hold) begin
      cmd = 4'd7;
      cmd_valid = 1'b1;
    end

    case (kind)
      0: begin
        check("idle_status", status, (m_st == 2) ? 2'b00 : 2'b10);
        check("idle_ready", cmd_ready, 1'b1);
        check("idle_neg", neg, m_neg);
        if (m_st == 2) check("idle_err_data", data, 4'hE);
      end
      1: begin
        lat = 0;
        do begin
          @(posedge clock);
          #1;
          lat++;
        end while (status !== 2'b11 && lat < 200);
        check("print_latency", lat, exp_lat);
        for (int k = 0; k < D; k++) begin
          if (k > 0) begin
            @(posedge clock);
            #1;
          end
          check($sformatf("print_pos%0d", k), pos, k);
          check($sformatf("print_data%0d(val %0d)", k, val), data, exp_digit(val, k));
          check("print_status", status, 2'b11);
        end
        cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        check("after_print_status", status, 2'b10);
        check("after_print_ready", cmd_ready, 1'b1);
        check("after_print_neg", neg, m_neg);
      end
      2: begin
        lat = 0;
        while (status !== 2'b00 && lat < 200) begin
          @(posedge clock);
          #1;
          lat++;
        end
        check("err_status", status, 2'b00);
        check("err_data", data, 4'hE);
        check("err_pos", pos, 0);
        check("err_ready", cmd_ready, 1'b1);
      end
      default: begin
        check("clear_status", status, 2'b10);
        check("clear_data", data, 4'h0);
        check("clear_pos", pos, 0);
        check("clear_neg", neg, 1'b0);
      end
    endcase
  endtask

  initial begin
    int r;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check("reset_status", status, 2'b10);
    check("reset_data", data, 4'h0);
    check("reset_pos", pos, 0);
    check("reset_neg", neg, 1'b0);
    check("reset_ready", cmd_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    // 12 + 34 = 46
    do_cmd(1); do_cmd(2); do_cmd(10); do_cmd(3); do_cmd(4); do_cmd(14);
    // 5 - 9 = -4, then chained + 1 = 5
    do_cmd(5); do_cmd(11); do_cmd(9); do_cmd(14);
    check("sub_neg", neg, 1'b1);
    do_cmd(10); do_cmd(1); do_cmd(14);
    // 123 * 45 = 5535
    do_cmd(1); do_cmd(2); do_cmd(3); do_cmd(12); do_cmd(4); do_cmd(5); do_cmd(14);
    // nine 9s: ninth ignored, then overflow on +1
    for (int i = 0; i < 9; i++) do_cmd(9);
    do_cmd(10); do_cmd(1); do_cmd(14);
    do_cmd(3);
    do_cmd(15);
`ifdef CALC_DIV_EN
    do_cmd(7); do_cmd(13); do_cmd(0); do_cmd(14); do_cmd(15);
    do_cmd(9); do_cmd(13); do_cmd(2); do_cmd(14);
`else
    do_cmd(7); do_cmd(13); do_cmd(15);
`endif
    // commands offered during a print are dropped
    do_cmd(3, 1'b1);
    do_cmd(4, 1'b1);
    do_cmd(15);
    do_cmd(10); do_cmd(6); do_cmd(14);

    // reset in the middle of a multiply
    do_cmd(1); do_cmd(2); do_cmd(12); do_cmd(3);
    send(4'd14);
    repeat (5) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midcalc_rst_status", status, 2'b10);
    check("midcalc_rst_data", data, 4'h0);
    check("midcalc_rst_pos", pos, 0);
    check("midcalc_rst_neg", neg, 1'b0);
    check("midcalc_rst_ready", cmd_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    do_cmd(14);
    do_cmd(15);

    // random keypad traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      do_cmd($urandom_range(0, 9));
      else if (r < 68) do_cmd($urandom_range(10, 12));
      else if (r < 82) do_cmd(14);
      else if (r < 94) do_cmd(15);
      else             do_cmd(13);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
